// File: rtl/systolic_2x2.sv
// 2x2 output-stationary MAC array computing C = A x B from skewed A/B wavefronts; SYSTOLIC_SAT_EN clamps on overflow.
// Latency: results registered one cycle after each load_in edge; done pulses after the 4th step.
// Backpressure: none; load_in is a step strobe and idle gaps simply hold all state.
module systolic_2x2 #(
  parameter logic [2:0] DATA_TYPE = 3'b011
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_in,
  input  logic [31:0] row_in_row0,
  input  logic [31:0] row_in_row1,
  input  logic [31:0] col_in_col0,
  input  logic [31:0] col_in_col1,
  output logic [63:0] result_row00,
  output logic [63:0] result_row01,
  output logic [63:0] result_row10,
  output logic [63:0] result_row11,
  output logic        carry_00,
  output logic        carry_01,
  output logic        carry_10,
  output logic        carry_11,
  output logic        done
);

  localparam logic IS_SIGNED = (DATA_TYPE == 3'b001) || (DATA_TYPE == 3'b010) ||
                               (DATA_TYPE == 3'b100);

  function automatic logic [63:0] decode(input logic [31:0] x);
    case (DATA_TYPE)
      3'b000:  decode = {56'd0, x[7:0]};
      3'b001:  decode = {{56{x[7]}}, x[7:0]};
      3'b010:  decode = {{48{x[15]}}, x[15:0]};
      3'b100:  decode = {{32{x[31]}}, x};
      default: decode = {32'd0, x};
    endcase
  endfunction

  logic [31:0] a00, a10, b00, b01;
  logic [1:0]  step_cnt;
  logic [63:0] acc     [4];
  logic        cy      [4];
  logic [63:0] op_a    [4];
  logic [63:0] op_b    [4];
  logic [63:0] prod    [4];
  logic [64:0] sum     [4];
  logic [63:0] acc_nxt [4];
  logic        ovf     [4];

  // PE index k = 2*row + col
  always_comb begin
    op_a[0] = decode(row_in_row0);
    op_b[0] = decode(col_in_col0);
    op_a[1] = decode(a00);
    op_b[1] = decode(col_in_col1);
    op_a[2] = decode(row_in_row1);
    op_b[2] = decode(b00);
    op_a[3] = decode(a10);
    op_b[3] = decode(b01);
    for (int k = 0; k < 4; k++) begin
      prod[k] = op_a[k] * op_b[k];
      sum[k]  = {1'b0, acc[k]} + {1'b0, prod[k]};
      ovf[k]  = IS_SIGNED ? ((acc[k][63] == prod[k][63]) && (sum[k][63] != acc[k][63]))
                          : sum[k][64];
      acc_nxt[k] = sum[k][63:0];
`ifdef SYSTOLIC_SAT_EN
      // once saturated, the value sticks until the next product start
      if (cy[k]) begin
        acc_nxt[k] = acc[k];
      end else if (ovf[k]) begin
        if (!IS_SIGNED)      acc_nxt[k] = 64'hFFFF_FFFF_FFFF_FFFF;
        else if (acc[k][63]) acc_nxt[k] = 64'h8000_0000_0000_0000;
        else                 acc_nxt[k] = 64'h7FFF_FFFF_FFFF_FFFF;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      step_cnt <= 2'd0;
      done     <= 1'b0;
      a00      <= 32'd0;
      a10      <= 32'd0;
      b00      <= 32'd0;
      b01      <= 32'd0;
      for (int k = 0; k < 4; k++) begin
        acc[k] <= 64'd0;
        cy[k]  <= 1'b0;
      end
    end else begin
      done <= 1'b0;
      if (load_in) begin
        for (int k = 0; k < 4; k++) begin
          if (step_cnt == 2'd0) begin
            acc[k] <= prod[k];
            cy[k]  <= 1'b0;
          end else begin
            acc[k] <= acc_nxt[k];
            cy[k]  <= cy[k] | ovf[k];
          end
        end
        // flush step: clear the skew pipeline so the next product starts clean
        if (step_cnt == 2'd3) begin
          step_cnt <= 2'd0;
          done     <= 1'b1;
          a00      <= 32'd0;
          a10      <= 32'd0;
          b00      <= 32'd0;
          b01      <= 32'd0;
        end else begin
          step_cnt <= step_cnt + 2'd1;
          a00      <= row_in_row0;
          a10      <= row_in_row1;
          b00      <= col_in_col0;
          b01      <= col_in_col1;
        end
      end
    end
  end

  assign result_row00 = acc[0];
  assign result_row01 = acc[1];
  assign result_row10 = acc[2];
  assign result_row11 = acc[3];
  assign carry_00     = cy[0];
  assign carry_01     = cy[1];
  assign carry_10     = cy[2];
  assign carry_11     = cy[3];

endmodule

// File: tb/tb_systolic_2x2.sv
// Directed bench for systolic_2x2: an unsigned (default) instance and a signed 8-bit instance share stimulus.
module tb_systolic_2x2;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_in;
  logic [31:0] r0, r1, c0, c1;

  logic [63:0] u00, u01, u10, u11, s00, s01, s10, s11;
  logic        ucy00, ucy01, ucy10, ucy11, scy00, scy01, scy10, scy11;
  logic        u_done, s_done;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  systolic_2x2 u_dut (
    .clk(clk), .rst(rst), .load_in(load_in),
    .row_in_row0(r0), .row_in_row1(r1), .col_in_col0(c0), .col_in_col1(c1),
    .result_row00(u00), .result_row01(u01), .result_row10(u10), .result_row11(u11),
    .carry_00(ucy00), .carry_01(ucy01), .carry_10(ucy10), .carry_11(ucy11),
    .done(u_done)
  );

  systolic_2x2 #(.DATA_TYPE(3'b001)) s_dut (
    .clk(clk), .rst(rst), .load_in(load_in),
    .row_in_row0(r0), .row_in_row1(r1), .col_in_col0(c0), .col_in_col1(c1),
    .result_row00(s00), .result_row01(s01), .result_row10(s10), .result_row11(s11),
    .carry_00(scy00), .carry_01(scy01), .carry_10(scy10), .carry_11(scy11),
    .done(s_done)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic check_u(input string tag, input logic [63:0] e00, e01, e10, e11);
    check($sformatf("%s_u00", tag), u00, e00);
    check($sformatf("%s_u01", tag), u01, e01);
    check($sformatf("%s_u10", tag), u10, e10);
    check($sformatf("%s_u11", tag), u11, e11);
  endtask

  task automatic check_s(input string tag, input logic [63:0] e00, e01, e10, e11);
    check($sformatf("%s_s00", tag), s00, e00);
    check($sformatf("%s_s01", tag), s01, e01);
    check($sformatf("%s_s10", tag), s10, e10);
    check($sformatf("%s_s11", tag), s11, e11);
  endtask

  // one systolic step; load_in stays high so consecutive calls are back-to-back
  task automatic step(input logic [31:0] a0, a1, b0, b1);
    @(negedge clk);
    r0 = a0; r1 = a1; c0 = b0; c1 = b1;
    load_in = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    load_in = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic twos_stream();
    step(32'd2, 32'd0, 32'd2, 32'd0);
    step(32'd2, 32'd2, 32'd2, 32'd2);
    step(32'd0, 32'd2, 32'd0, 32'd2);
    step(32'd0, 32'd0, 32'd0, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [63:0] ovf_exp;
`ifdef SYSTOLIC_SAT_EN
    ovf_exp = 64'hFFFF_FFFF_FFFF_FFFF;
`else
    ovf_exp = 64'hFFFF_FFFC_0000_0002;
`endif
    rst = 1'b1; load_in = 1'b0; r0 = '0; r1 = '0; c0 = '0; c1 = '0;
    repeat (2) @(posedge clk);
    #1;
    check_u("reset", 64'd0, 64'd0, 64'd0, 64'd0);
    check("reset_carry", {ucy00, ucy01, ucy10, ucy11}, 4'b0000);
    check("reset_done", u_done, 1'b0);
    rst = 1'b0;

    // all-twos stream with idle gaps, intermediate values included
    step(32'd2, 32'd0, 32'd2, 32'd0);
    check_u("twos_s1", 64'd4, 64'd0, 64'd0, 64'd0);
    check("twos_s1_done", u_done, 1'b0);
    idle();
    step(32'd2, 32'd2, 32'd2, 32'd2);
    check_u("twos_s2", 64'd8, 64'd4, 64'd4, 64'd0);
    idle();
    step(32'd0, 32'd2, 32'd0, 32'd2);
    check_u("twos_s3", 64'd8, 64'd8, 64'd8, 64'd4);
    check("twos_s3_done", u_done, 1'b0);
    idle();
    step(32'd0, 32'd0, 32'd0, 32'd0);
    check_u("twos_s4", 64'd8, 64'd8, 64'd8, 64'd8);
    check("twos_carry", {ucy00, ucy01, ucy10, ucy11}, 4'b0000);
    check("twos_done_pulse", u_done, 1'b1);
    idle();
    check("twos_done_clear", u_done, 1'b0);
    check_u("twos_hold", 64'd8, 64'd8, 64'd8, 64'd8);

    // A=[[1,2],[3,4]] B=[[5,6],[7,8]] back-to-back, then immediate restart
    step(32'd1, 32'd0, 32'd5, 32'd0);
    step(32'd2, 32'd3, 32'd7, 32'd6);
    step(32'd0, 32'd4, 32'd0, 32'd8);
    step(32'd0, 32'd0, 32'd0, 32'd0);
    check_u("ab", 64'd19, 64'd22, 64'd43, 64'd50);
    check("ab_done", u_done, 1'b1);
    step(32'd2, 32'd0, 32'd2, 32'd0);
    check_u("restart_s1", 64'd4, 64'd0, 64'd0, 64'd0);
    check("restart_s1_done", u_done, 1'b0);
    step(32'd2, 32'd2, 32'd2, 32'd2);
    step(32'd0, 32'd2, 32'd0, 32'd2);
    step(32'd0, 32'd0, 32'd0, 32'd0);
    check_u("restart", 64'd8, 64'd8, 64'd8, 64'd8);
    check("restart_done", u_done, 1'b1);
    idle();

    // unsigned overflow on PE00: (2^32-1)^2 twice exceeds 2^64
    step(32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFF, 32'd0);
    check("ovf_s1_val", u00, 64'hFFFF_FFFE_0000_0001);
    check("ovf_s1_carry", ucy00, 1'b0);
    step(32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFF, 32'd0);
    check("ovf_s2_val", u00, ovf_exp);
    check("ovf_s2_carry", ucy00, 1'b1);
    step(32'd0, 32'd0, 32'd0, 32'd0);
    step(32'd0, 32'd0, 32'd0, 32'd0);
    check("ovf_hold_val", u00, ovf_exp);
    check("ovf_sticky", {ucy00, ucy01, ucy10, ucy11}, 4'b1000);
    check_u("ovf_others", ovf_exp, 64'd0, 64'd0, 64'd0);
    idle();
    twos_stream();
    check("ovf_carry_clear", ucy00, 1'b0);
    check("ovf_restart_val", u00, 64'd8);
    idle();

    // signed 8-bit: -2 everywhere, then 0x80 x 0x02 with junk upper bits
    step(32'h0000_00FE, 32'd0, 32'h0000_00FE, 32'd0);
    step(32'h0000_00FE, 32'h0000_00FE, 32'h0000_00FE, 32'h0000_00FE);
    step(32'd0, 32'h0000_00FE, 32'd0, 32'h0000_00FE);
    step(32'd0, 32'd0, 32'd0, 32'd0);
    check_s("sgn_m2", 64'd8, 64'd8, 64'd8, 64'd8);
    check("sgn_m2_carry", {scy00, scy01, scy10, scy11}, 4'b0000);
    check("sgn_m2_done", s_done, 1'b1);
    idle();
    step(32'h1234_5680, 32'h5A5A_5A00, 32'hABCD_EF02, 32'h5A5A_5A00);
    step(32'h1234_5680, 32'h1234_5680, 32'hABCD_EF02, 32'hABCD_EF02);
    step(32'h5A5A_5A00, 32'h1234_5680, 32'h5A5A_5A00, 32'hABCD_EF02);
    step(32'h5A5A_5A00, 32'h5A5A_5A00, 32'h5A5A_5A00, 32'h5A5A_5A00);
    check_s("sgn_x80", 64'hFFFF_FFFF_FFFF_FE00, 64'hFFFF_FFFF_FFFF_FE00,
            64'hFFFF_FFFF_FFFF_FE00, 64'hFFFF_FFFF_FFFF_FE00);
    check("sgn_x80_carry", {scy00, scy01, scy10, scy11}, 4'b0000);
    idle();

    // reset after step 2 aborts the product
    step(32'd2, 32'd0, 32'd2, 32'd0);
    step(32'd2, 32'd2, 32'd2, 32'd2);
    check("rst_mid_pre", u00, 64'd8);
    @(negedge clk);
    rst = 1'b1; load_in = 1'b0;
    @(posedge clk);
    #1;
    check_u("rst_mid", 64'd0, 64'd0, 64'd0, 64'd0);
    check("rst_mid_carry", {ucy00, ucy01, ucy10, ucy11}, 4'b0000);
    check("rst_mid_done", u_done, 1'b0);
    rst = 1'b0;
    step(32'd2, 32'd0, 32'd2, 32'd0);
    step(32'd2, 32'd2, 32'd2, 32'd2);
    check("rst_new_s2_done", u_done, 1'b0);
    step(32'd0, 32'd2, 32'd0, 32'd2);
    check("rst_new_s3_done", u_done, 1'b0);
    step(32'd0, 32'd0, 32'd0, 32'd0);
    check_u("rst_new", 64'd8, 64'd8, 64'd8, 64'd8);
    check("rst_new_done", u_done, 1'b1);
    idle();
    check("rst_new_done_clear", u_done, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/systolic_2x2.md
Name: systolic_2x2

Overview:
- 2x2 output-stationary systolic array of multiply-accumulate processing elements (PEs) computing C = A x B for 2x2 matrices.
- Operands are streamed in as skewed wavefronts, one wavefront per load_in strobe: A rows enter from the left edge, B columns from the top edge.
- Each PE holds one 64-bit C element plus an overflow flag.
- done pulses when a full product is complete. The block sits behind a host/DMA stream feeder in the matrix-multiply datapath.

Parameters:
- DATA_TYPE, 3'b011, operand format.
  - 000: unsigned 8-bit.
  - 001: signed 8-bit.
  - 010: signed 16-bit.
  - 011: unsigned 32-bit.
  - 100: signed 32-bit.
  - Any other code behaves as 011.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- load_in  in  1  step strobe; each high cycle is one systolic step.
- row_in_row0  in  32  A-row-0 element entering PE00 from the left.
- row_in_row1  in  32  A-row-1 element entering PE10 from the left.
- col_in_col0  in  32  B-column-0 element entering PE00 from the top.
- col_in_col1  in  32  B-column-1 element entering PE01 from the top.
- result_row00, result_row01, result_row10, result_row11  out  64 each  accumulator of PE(i,j), i.e. C[i][j].
- carry_00, carry_01, carry_10, carry_11  out  1 each  sticky overflow flag of PE(i,j).
- done  out  1  one-cycle pulse marking product complete.

Behaviour:
- Reset (synchronous): all results = 0, all carries = 0, done = 0, all pass registers = 0, step counter = 0. Reset mid-stream aborts the product; the next load_in is treated as step 1.
- Operand decode: take the low 8/16/32 bits of each input per DATA_TYPE, then zero-extend (unsigned) or sign-extend (signed) to 64 bits. The product is 64 bits.
- Pass registers: a00, a10 carry A rightward; b00, b01 carry B downward. They update only on load_in.
- PE operand sources on a step:
  - PE00: a = row_in_row0, b = col_in_col0.
  - PE01: a = a00 (pre-edge value), b = col_in_col1.
  - PE10: a = row_in_row1, b = b00 (pre-edge value).
  - PE11: a = a10, b = b01.
- Pass register updates on the same edge:
  - a00 <= row_in_row0; b00 <= col_in_col0.
  - a10 <= row_in_row1; b01 <= col_in_col1.
- Step counter runs 0..3 and counts accepted load_in strobes. One product takes 3N-2 = 4 steps: 3 data wavefronts plus 1 flush wavefront.
- Accumulate rule on a load_in edge:
  - Counter == 0 (first step): acc <= product, carry <= 0, i.e. auto-clear.
  - Otherwise: acc <= acc + product.
- Results are registered and visible the cycle after the step edge.
- Overflow:
  - Unsigned formats: carry is set on carry-out of bit 63.
  - Signed formats: carry is set on two's-complement overflow of the 64-bit add.
  - carry stays set until the next product start or reset. The accumulator wraps modulo 2^64 unless SYSTOLIC_SAT_EN is defined.
- Completion:
  - On the edge that accepts step 4, the counter returns to 0, all pass registers load 0 (not the inputs), and done is registered high for exactly one cycle.
  - Results then hold until the next load_in.
- load_in low: nothing changes; results hold; done = 0 except for its single pulse cycle.
- Steps may be back-to-back (load_in held high for consecutive cycles); each high cycle is one step. Arbitrary idle gaps between steps are legal.
- load_in in the cycle done is high: accepted as step 1 of a new product. No dead cycle is required.

Optional Feature:
- Macro: SYSTOLIC_SAT_EN.
- Defined: on overflow the accumulator clamps instead of wrapping.
  - Unsigned: clamps to 64'hFFFF_FFFF_FFFF_FFFF.
  - Signed: clamps to 64'h7FFF_FFFF_FFFF_FFFF or 64'h8000_0000_0000_0000, matching the overflow direction.
  - carry is still set, and further adds keep the saturated value.
- Undefined: modulo-2^64 wrap, with carry flagging the overflow.

Test Plan:
- All-twos product, DATA_TYPE=011, one load_in pulse per step with idle gaps. Four steps (row0, row1, col0, col1):
  - Step 1: (2, 0, 2, 0).
  - Step 2: (2, 2, 2, 2).
  - Step 3: (0, 2, 0, 2).
  - Step 4: (0, 0, 0, 0).
  - Required: all four results = 8, all carries = 0, done high exactly one cycle after the step-4 edge.
- Intermediate values during the all-twos stream:
  - After step 1: result_row00 = 4, others = 0.
  - After step 2: result_row00 = 8, result_row01 = 4, result_row10 = 4, result_row11 = 0.
  - After step 3: result_row11 = 4.
- A = [[1,2],[3,4]], B = [[5,6],[7,8]], same skew, back-to-back steps:
  - Required: 19, 22, 43, 50.
  - Then restart immediately with the all-twos stream: all results = 8 (auto-clear verified).
- Overflow, DATA_TYPE=011:
  - Preload result_row00 near 2^64 via repeated products of FFFF_FFFF x FFFF_FFFF.
  - Required: carry_00 = 1 on wrap; value wraps (saturates to all-ones with SYSTOLIC_SAT_EN).
- Signed, DATA_TYPE=001, all operands 8'hFE (-2):
  - Required: all results = 8, carries = 0.
  - Operands 8'h80 and upper input bits nonzero: upper bits ignored.
- rst asserted after step 2:
  - Required: all outputs 0 on the next cycle.
  - A fresh 4-step stream then yields correct results and a single done pulse.
